serial_adder_n: RTL

//   Parametrised bit-serial adder/subtractor: adds two WIDTH-bit operands LSB-first, one bit per clock,

---
 rtl/adder_pkg.sv | 14 +
 rtl/bit_full_adder.sv | 13 +
 rtl/serial_adder_n.sv | 130 +++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial datapath units.
package adder_pkg;

    // Handshake FSM encoding shared by the serial arithmetic blocks.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } adder_state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/bit_full_adder.sv
// Single-bit full adder cell; the only arithmetic element of the serial adder.
module bit_full_adder (
    input  logic inA,
    input  logic inB,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = inA ^ inB ^ cin;
    assign cout = (inA & inB) | (inA & cin) | (inB & cin);

endmodule

// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, WIDTH cycles per result.
//
//   state   | meaning
//   IDLE    | waiting for start, last result (or reset zeros) on sum/cout/ovf
//   RUN     | one operand bit per cycle through the full adder
//   DONE    | result valid for one cycle; start here chains the next operation
module serial_adder_n
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder_n: WIDTH out of supported range");
    end

    adder_state_e   state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic           carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;

    logic           fa_s;
    logic           fa_co;

    bit_full_adder u_fa (
        .inA  (a_q[0]),
        .inB  (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_s),
        .cout (fa_co)
    );

    // Next-state, operand shifting and result capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    sh_d    = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sh_d    = {fa_s, sh_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_co;
                if (cnt_q == LAST_BIT) begin
                    // On the MSB cycle carry_q is the carry into the MSB.
                    state_d = ST_DONE;
                    sum_d   = {fa_s, sh_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
